sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single RW port (port 0) of the sky130_sram_2kbyte_1rw1r_32x512_8 macro between two requesters: m0 (CPU data/instr bus) and m1 (host/DMA loader).
- Each requester uses a valid/ready handshake. The arbiter picks one request at a time, round-robin, and drives the active-low macro controls (csb0/web0) from registers.
- It captures the read data and returns it with a one-cycle ready pulse.
- Sits between picorv32_woready/host logic and the SRAM macro inside the SRAM-backed top.

Parameters:
- ADDR_WIDTH, 9, word address width of the macro port.
- DATA_WIDTH, 32, data width.
- NUM_WMASKS, 4, byte-lane write-mask width (DATA_WIDTH/8).

Ports:
- clk  input  1  single clock for arbiter and macro.
- resetn  input  1  asynchronous active-low reset.
- m0_valid  input  1  request from requester 0; held until m0_ready.
- m0_addr  input  ADDR_WIDTH  word address.
- m0_wdata  input  DATA_WIDTH  write data.
- m0_wstrb  input  NUM_WMASKS  byte strobes; 0 = read, nonzero = write.
- m0_rdata  output  DATA_WIDTH  read data, valid while m0_ready=1.
- m0_ready  output  1  one-cycle completion pulse.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready  same as m0_*, for requester 1.
- sram_csb0  output  1  macro chip select, active low.
- sram_web0  output  1  macro write enable, active low.
- sram_wmask0  output  NUM_WMASKS  macro write mask.
- sram_addr0  output  ADDR_WIDTH  macro address.
- sram_din0  output  DATA_WIDTH  macro write data.
- sram_dout0  input  DATA_WIDTH  macro read data.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (resetn).
- Reset values:
  - state=IDLE, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
  - m0_ready=m1_ready=0, m0_rdata=m1_rdata=0.
  - last_gnt=1, so m0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If neither valid, stay in IDLE.
  - If exactly one valid, grant it.
  - If both valid, grant the requester != last_gnt.
  - On grant: register sram_csb0=0, sram_addr0=addr, sram_din0=wdata, sram_web0=(wstrb==0), sram_wmask0=wstrb; set gnt; go to ACCESS.
- ACCESS: the macro samples its inputs on this cycle's closing edge. Register sram_csb0=1, sram_web0=1, sram_wmask0=0; go to WAIT.
- WAIT: sram_dout0 is valid. Register the granted rdata <= sram_dout0 (reads only; writes leave rdata unchanged). Set the granted ready=1, last_gnt=gnt; go to RESP.
- RESP:
  - The granted ready is high for exactly this cycle; the other ready stays 0. Next state is IDLE.
  - A requester may drop valid, or present a new request, from the cycle after RESP.
- Latency: valid seen in IDLE at cycle 0 -> ready high in cycle 3. Maximum throughput is one access per 4 cycles.
- Macro control outputs come only from registers. No combinational path from any m*_valid to the sram_* outputs.
- Once granted, the request is frozen: changes on the requester inputs after the grant cycle are ignored until RESP.
- Simultaneous events: a new valid from the non-granted requester waits. With both pending, grants alternate strictly, so starvation is bounded at 4 cycles of waiting per competing access.
- Reset mid-operation: return to IDLE immediately with reset values. A write already sampled by the macro may have landed; nothing else completes, and no ready is issued.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined:
  - Adds ports stats_clr (input 1), gnt_cnt0 and gnt_cnt1 (output 16 each).
  - Counter n increments on each RESP for requester n and saturates at 16'hFFFF.
  - stats_clr zeroes both counters synchronously and takes priority over an increment in the same cycle.
  - Counters reset to 0.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package sram_arb_pkg:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3).
  - Requester index constants REQ_M0=1'b0, REQ_M1=1'b1.
  - Stats counter width constant STAT_W=16.
- Sub-module sram_arb_rr: a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_gnt. Outputs: gnt_valid, gnt_idx.
  - Instantiated once; the FSM, registers and muxing stay in the top.

Test Plan:
- m0 write addr=9'h010, wdata=32'hDEADBEEF, wstrb=4'hF -> csb0=0/web0=0/wmask0=F in cycle 1; m0_ready in cycle 3. Then an m0 read of 9'h010 -> m0_rdata=32'hDEADBEEF with m0_ready.
- Partial write wstrb=4'b0010, wdata=32'h0000AB00, over 32'h11223344 at 9'h1FF -> read-back 32'h1122AB44 (address wrap edge 9'h1FF).
- m0 and m1 both valid continuously for 4 reads -> grant order m0, m1, m0, m1. Readies never overlap and are spaced 4 cycles apart.
- m1 alone valid with m0 idle -> m1 granted in cycle 0 regardless of last_gnt. m0_ready stays 0 and m0_rdata is unchanged.
- resetn pulsed low during the ACCESS state of a read -> outputs return to reset values asynchronously, no ready pulse. After release, a re-issued request completes normally.
- With SRAM_ARB_STATS_EN: 3 m0 and 2 m1 accesses -> gnt_cnt0=3, gnt_cnt1=2. stats_clr asserted in the same cycle as an RESP -> both counters read 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM encoding, requester
// indices and the width of the optional grant statistics counters.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    localparam int STAT_W = 16;

endpackage

// File: rtl/sram_arb_rr.sv
// Combinational 2-way round-robin picker. A lone request always wins;
// with both requesting, the one that did not win last time is chosen.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Pick a winner from the current request vector and the previous grant.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = REQ_M0;
        if (req == 2'b11) begin
            gnt_idx = ~last_gnt;
        end else if (req[1]) begin
            gnt_idx = REQ_M1;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the RW port of the sky130 1rw1r 32x512 SRAM macro between two
// valid/ready requesters (m0 = CPU, m1 = host/DMA loader).
//
// Handshake: a requester raises valid with addr/wdata/wstrb stable and holds
// them until its ready pulses for one cycle; ready is the completion, and
// rdata is meaningful only while ready is high. Inputs are captured on the
// grant edge, so later changes are ignored until the response. A new request
// may be presented from the cycle after the ready pulse.
//
// One access takes four cycles: IDLE (grant) -> ACCESS (macro samples) ->
// WAIT (dout valid, captured) -> RESP (ready high). All macro controls are
// registered; no valid input reaches the sram_* outputs combinationally.
//
// Optional: define SRAM_ARB_STATS_EN to add stats_clr and per-requester
// saturating grant counters gnt_cnt0/gnt_cnt1.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  m0_valid,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [NUM_WMASKS-1:0] m0_wstrb,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ready,

    input  logic                  m1_valid,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [NUM_WMASKS-1:0] m1_wstrb,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ready,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,

`ifdef SRAM_ARB_STATS_EN
    input  logic                  stats_clr,
    output logic [STAT_W-1:0]     gnt_cnt0,
    output logic [STAT_W-1:0]     gnt_cnt1,
`endif

    output logic [1:0]            state_dbg
);

    arb_state_t state;
    arb_state_t state_next;

    logic gnt;        // requester owning the current access
    logic last_gnt;   // requester of the last completed access
    logic req_write;  // current access is a write (rdata left untouched)

    logic pick_valid;
    logic pick_idx;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [NUM_WMASKS-1:0] sel_wstrb;

    assign state_dbg = state;

    sram_arb_rr u_rr (
        .req       ({m1_valid, m0_valid}),
        .last_gnt  (last_gnt),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // Route the winning requester's fields toward the grant registers.
    always_comb begin
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_wstrb = m0_wstrb;
        if (pick_idx == REQ_M1) begin
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_wstrb = m1_wstrb;
        end
    end

    // Next-state logic: only IDLE waits; every other state advances each cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = ACCESS;
            ACCESS:  state_next = WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Macro control, grant bookkeeping, read capture and ready pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
            gnt         <= REQ_M0;
            last_gnt    <= REQ_M1;
            req_write   <= 1'b0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sram_csb0   <= 1'b0;
                        sram_addr0  <= sel_addr;
                        sram_din0   <= sel_wdata;
                        sram_web0   <= (sel_wstrb == '0);
                        sram_wmask0 <= sel_wstrb;
                        gnt         <= pick_idx;
                        req_write   <= (sel_wstrb != '0);
                    end
                end
                ACCESS: begin
                    sram_csb0   <= 1'b1;
                    sram_web0   <= 1'b1;
                    sram_wmask0 <= '0;
                end
                WAIT: begin
                    if (gnt == REQ_M0) begin
                        m0_ready <= 1'b1;
                        if (!req_write) m0_rdata <= sram_dout0;
                    end else begin
                        m1_ready <= 1'b1;
                        if (!req_write) m1_rdata <= sram_dout0;
                    end
                    last_gnt <= gnt;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SRAM_ARB_STATS_EN
    // Saturating per-requester grant counters; clear beats increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (stats_clr) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (state == RESP) begin
            if (gnt == REQ_M0 && gnt_cnt0 != {STAT_W{1'b1}}) gnt_cnt0 <= gnt_cnt0 + STAT_W'(1);
            if (gnt == REQ_M1 && gnt_cnt1 != {STAT_W{1'b1}}) gnt_cnt1 <= gnt_cnt1 + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter with a behavioural model of the
// SRAM macro port (registered read data one edge after chip select).
module tb_sram_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [8:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;
    logic [1:0]  state_dbg;
`ifdef SRAM_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    sram_port_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_valid    (m0_valid),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wstrb    (m0_wstrb),
        .m0_rdata    (m0_rdata),
        .m0_ready    (m0_ready),
        .m1_valid    (m1_valid),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wstrb    (m1_wstrb),
        .m1_rdata    (m1_rdata),
        .m1_ready    (m1_ready),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0),
`ifdef SRAM_ARB_STATS_EN
        .stats_clr   (stats_clr),
        .gnt_cnt0    (gnt_cnt0),
        .gnt_cnt1    (gnt_cnt1),
`endif
        .state_dbg   (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: samples on the rising edge while selected.
    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit idx, input logic [8:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        if (idx == 1'b0) begin
            m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
        end else begin
            m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
        end
    endtask

    task automatic idle_req(input bit idx);
        if (idx == 1'b0) begin
            m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        end else begin
            m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        end
    endtask

    // Returns the number of edges until ready, or -1 after 20 edges.
    task automatic wait_ready(input bit idx, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if ((idx == 1'b0 && m0_ready) || (idx == 1'b1 && m1_ready)) begin
                cyc = i;
                return;
            end
        end
    endtask

    // One complete access; leaves the arbiter back in IDLE.
    task automatic do_txn(input bit idx, input logic [8:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output int cyc);
        drive_req(idx, addr, wdata, wstrb);
        wait_ready(idx, cyc);
        idle_req(idx);
        step();
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_req(1'b0);
        idle_req(1'b1);
`ifdef SRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        resetn = 1'b0;
        #12;
        checks++;
        if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || sram_wmask0 !== 4'h0 ||
            sram_addr0 !== 9'h0 || sram_din0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_sram: csb=%b web=%b wmask=%h addr=%h din=%h, want 1 1 0 0 0",
                     sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0);
        end
        checks++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || m0_rdata !== 32'h0 ||
            m1_rdata !== 32'h0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_resp: rdy=%b%b rdata0=%h rdata1=%h state=%0d, want 00 0 0 0",
                     m0_ready, m1_ready, m0_rdata, m1_rdata, state_dbg);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        int cyc;
        drive_req(1'b0, 9'h010, 32'hDEADBEEF, 4'hF);
        step();
        checks++;
        if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_wmask0 !== 4'hF ||
            sram_addr0 !== 9'h010 || sram_din0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_ctrl: csb=%b web=%b wmask=%h addr=%h din=%h, want 0 0 f 010 deadbeef",
                     sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0);
        end
        step();
        checks++;
        if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || sram_wmask0 !== 4'h0) begin
            errors++;
            $display("FAIL write_deselect: csb=%b web=%b wmask=%h, want 1 1 0",
                     sram_csb0, sram_web0, sram_wmask0);
        end
        step();
        checks++;
        if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_latency: rdy0=%b rdy1=%b at cycle 3, want 1 0", m0_ready, m1_ready);
        end
        idle_req(1'b0);
        step();
        checks++;
        if (m0_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_pulse_width: rdy0=%b in cycle 4, want 0", m0_ready);
        end
        drive_req(1'b0, 9'h010, 32'h0, 4'h0);
        wait_ready(1'b0, cyc);
        checks++;
        if (cyc != 3 || m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_back: cyc=%0d rdata=%h, want 3 deadbeef", cyc, m0_rdata);
        end
        idle_req(1'b0);
        step();
    endtask

    task automatic test_partial_write();
        int cyc;
        do_txn(1'b0, 9'h1FF, 32'h11223344, 4'hF, cyc);
        drive_req(1'b0, 9'h1FF, 32'h0000AB00, 4'b0010);
        step();
        // Requester inputs change after the grant; the access must not follow.
        m0_wdata = 32'hFFFFFFFF;
        m0_addr  = 9'h000;
        m0_wstrb = 4'hF;
        checks++;
        if (sram_wmask0 !== 4'b0010 || sram_din0 !== 32'h0000AB00 || sram_addr0 !== 9'h1FF) begin
            errors++;
            $display("FAIL partial_ctrl: wmask=%h din=%h addr=%h, want 2 0000ab00 1ff",
                     sram_wmask0, sram_din0, sram_addr0);
        end
        wait_ready(1'b0, cyc);
        idle_req(1'b0);
        step();
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL partial_latency: ready after %0d more edges, want 2", cyc);
        end
        drive_req(1'b0, 9'h1FF, 32'h0, 4'h0);
        wait_ready(1'b0, cyc);
        checks++;
        if (cyc != 3 || m0_rdata !== 32'h1122AB44) begin
            errors++;
            $display("FAIL partial_read: cyc=%0d rdata=%h, want 3 1122ab44", cyc, m0_rdata);
        end
        idle_req(1'b0);
        step();
    endtask

    task automatic test_contention();
        int          r0_cyc[2], r1_cyc[2];
        logic [31:0] r0_dat[2], r1_dat[2];
        int          n0, n1, overlap;
        n0 = 0; n1 = 0; overlap = 0;
        for (int i = 0; i < 2; i++) begin
            r0_cyc[i] = -1; r1_cyc[i] = -1; r0_dat[i] = '0; r1_dat[i] = '0;
        end
        apply_reset();
        drive_req(1'b0, 9'h010, 32'h0, 4'h0);
        drive_req(1'b1, 9'h1FF, 32'h0, 4'h0);
        for (int c = 1; c <= 18; c++) begin
            step();
            if (m0_ready && m1_ready) overlap++;
            if (m0_ready && n0 < 2) begin
                r0_cyc[n0] = c; r0_dat[n0] = m0_rdata; n0++;
                if (n0 == 1) m0_addr = 9'h1FF; else idle_req(1'b0);
            end
            if (m1_ready && n1 < 2) begin
                r1_cyc[n1] = c; r1_dat[n1] = m1_rdata; n1++;
                if (n1 == 1) m1_addr = 9'h010; else idle_req(1'b1);
            end
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL rr_overlap: %0d cycles with both ready, want 0", overlap);
        end
        checks++;
        if (r0_cyc[0] != 3 || r1_cyc[0] != 7 || r0_cyc[1] != 11 || r1_cyc[1] != 15) begin
            errors++;
            $display("FAIL rr_order: m0 at %0d,%0d m1 at %0d,%0d, want 3,11 and 7,15",
                     r0_cyc[0], r0_cyc[1], r1_cyc[0], r1_cyc[1]);
        end
        checks++;
        if (r0_dat[0] !== 32'hDEADBEEF || r1_dat[0] !== 32'h1122AB44 ||
            r0_dat[1] !== 32'h1122AB44 || r1_dat[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rr_data: m0 %h,%h m1 %h,%h, want deadbeef,1122ab44 and 1122ab44,deadbeef",
                     r0_dat[0], r0_dat[1], r1_dat[0], r1_dat[1]);
        end
    endtask

    task automatic test_m1_alone();
        int cyc;
        logic m0_seen;
        m0_seen = 1'b0;
        drive_req(1'b1, 9'h010, 32'h0, 4'h0);
        step();
        checks++;
        if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b1 || sram_addr0 !== 9'h010) begin
            errors++;
            $display("FAIL m1_grant: csb=%b web=%b addr=%h, want 0 1 010", sram_csb0, sram_web0, sram_addr0);
        end
        cyc = -1;
        for (int i = 2; i <= 6; i++) begin
            step();
            if (m0_ready) m0_seen = 1'b1;
            if (m1_ready && cyc < 0) begin
                cyc = i;
                checks++;
                if (m1_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL m1_rdata: got %h, want deadbeef", m1_rdata);
                end
                idle_req(1'b1);
            end
        end
        checks++;
        if (cyc != 3 || m0_seen || m0_rdata !== 32'h1122AB44) begin
            errors++;
            $display("FAIL m1_alone: m1 ready at %0d m0_ready seen=%b m0_rdata=%h, want 3 0 1122ab44",
                     cyc, m0_seen, m0_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic rdy_seen;
        rdy_seen = 1'b0;
        drive_req(1'b0, 9'h010, 32'h0, 4'h0);
        step();
        checks++;
        if (state_dbg !== 2'd1) begin
            errors++;
            $display("FAIL mid_in_access: state=%0d, want 1", state_dbg);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (sram_csb0 !== 1'b1 || state_dbg !== 2'd0 || m0_rdata !== 32'h0 ||
            m1_rdata !== 32'h0 || m0_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: csb=%b state=%0d rdata0=%h rdata1=%h rdy0=%b, want 1 0 0 0 0",
                     sram_csb0, state_dbg, m0_rdata, m1_rdata, m0_ready);
        end
        idle_req(1'b0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m0_ready || m1_ready) rdy_seen = 1'b1;
        end
        checks++;
        if (rdy_seen) begin
            errors++;
            $display("FAIL mid_no_ready: got a ready after reset, want none");
        end
        drive_req(1'b0, 9'h1FF, 32'h0, 4'h0);
        wait_ready(1'b0, cyc);
        checks++;
        if (cyc != 3 || m0_rdata !== 32'h1122AB44) begin
            errors++;
            $display("FAIL mid_reissue: cyc=%0d rdata=%h, want 3 1122ab44", cyc, m0_rdata);
        end
        idle_req(1'b0);
        step();
    endtask

`ifdef SRAM_ARB_STATS_EN
    task automatic test_stats();
        int cyc;
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        checks++;
        if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear: cnt0=%0d cnt1=%0d, want 0 0", gnt_cnt0, gnt_cnt1);
        end
        do_txn(1'b0, 9'h010, 32'h0, 4'h0, cyc);
        do_txn(1'b1, 9'h010, 32'h0, 4'h0, cyc);
        do_txn(1'b0, 9'h1FF, 32'h0, 4'h0, cyc);
        do_txn(1'b1, 9'h1FF, 32'h0, 4'h0, cyc);
        do_txn(1'b0, 9'h010, 32'h0, 4'h0, cyc);
        checks++;
        if (gnt_cnt0 !== 16'd3 || gnt_cnt1 !== 16'd2) begin
            errors++;
            $display("FAIL stats_count: cnt0=%0d cnt1=%0d, want 3 2", gnt_cnt0, gnt_cnt1);
        end
        drive_req(1'b0, 9'h010, 32'h0, 4'h0);
        wait_ready(1'b0, cyc);
        idle_req(1'b0);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        checks++;
        if (cyc != 3 || gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL stats_clr_priority: cyc=%0d cnt0=%0d cnt1=%0d, want 3 0 0",
                     cyc, gnt_cnt0, gnt_cnt1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_contention();
        test_m1_alone();
        test_reset_mid();
`ifdef SRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
